// File: rtl/shape_pkg.sv
// Shared types for the shape display controller.
//   shape_t      : label shown on the HEX display, or SH_NONE for blank
//   ctrl_state_t : controller FSM states
//   classify()   : priority encode of the per-frame classifier flags
package shape_pkg;

  typedef enum logic [1:0] {
    SH_NONE     = 2'd0,
    SH_CIRCLE   = 2'd1,
    SH_SQUARE   = 2'd2,
    SH_TRIANGLE = 2'd3
  } shape_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_SHOW    = 2'd2
  } ctrl_state_t;

  // Circle wins over square, square over triangle, so a frame that
  // matches several shapes still has exactly one class.
  function automatic shape_t classify(input logic c, input logic s, input logic t);
    if (c) return SH_CIRCLE;
    else if (s) return SH_SQUARE;
    else if (t) return SH_TRIANGLE;
    else return SH_NONE;
  endfunction

endpackage

// File: rtl/shape_sat_counter.sv
// Saturating up-counter used for the confirm, hold and miss counts.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : restart the count (loads 1 when inc is also set, else 0)
//   inc        : count one event, stops at MAX
//   count      : current count, $clog2(MAX+1) bits
//   at_max     : count has reached MAX
module shape_sat_counter #(
  parameter int MAX = 1,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(MAX));

  // clr together with inc lets a restart count the current event in one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/shape_display_ctrl.sv
// Turns per-frame classifier results into a stable, flicker-free shape label
// for the HEX display.  A shape must be seen on CONFIRM_FRAMES consecutive
// frames to be shown, stays up at least HOLD_FRAMES frames, and is blanked
// after TIMEOUT_FRAMES consecutive empty frames once the hold has run out.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   frame_done                          : one-cycle strobe, det_* valid only then
//   det_circle, det_square, det_triangle: classifier flags for this frame
//   clear                               : synchronous return to blank/idle
//   circle, square, triangle            : registered one-hot label (or all 0)
//   label_change                        : one-cycle pulse when the label changes
module shape_display_ctrl
  import shape_pkg::*;
#(
  parameter int CONFIRM_FRAMES = 3,
  parameter int HOLD_FRAMES    = 30,
  parameter int TIMEOUT_FRAMES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_done,
  input  logic det_circle,
  input  logic det_square,
  input  logic det_triangle,
  input  logic clear,
  output logic circle,
  output logic square,
  output logic triangle,
  output logic label_change
);

  localparam int CONF_W = $clog2(CONFIRM_FRAMES + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(TIMEOUT_FRAMES - 1);

  ctrl_state_t state, state_n;
  shape_t      shown, shown_n;
  shape_t      cand, cand_n;
  shape_t      cls;
  shape_t      commit_shape;
  logic        label_change_n;
  logic        do_commit, do_start;

  logic              conf_clr, conf_inc, conf_at_max;
  logic              hold_clr, hold_inc, hold_at_max;
  logic              miss_clr, miss_inc, miss_at_max;
  logic [CONF_W-1:0] conf_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic              conf_done, hold_expired, miss_timeout;

  assign cls = classify(det_circle, det_square, det_triangle);

  // conf_done: this agreeing frame is the last one needed to commit.
  // miss_timeout: this empty frame brings the miss count to the limit.
  assign conf_done    = conf_at_max || (conf_cnt >= CONF_LAST);
  assign hold_expired = hold_at_max || (hold_cnt >= HOLD_MAX);
  assign miss_timeout = miss_at_max || (miss_cnt >= MISS_LAST);

  shape_sat_counter #(.MAX(CONFIRM_FRAMES)) u_conf (
    .clk(clk), .reset(reset), .clr(conf_clr), .inc(conf_inc),
    .count(conf_cnt), .at_max(conf_at_max)
  );

  shape_sat_counter #(.MAX(HOLD_FRAMES)) u_hold (
    .clk(clk), .reset(reset), .clr(hold_clr), .inc(hold_inc),
    .count(hold_cnt), .at_max(hold_at_max)
  );

  shape_sat_counter #(.MAX(TIMEOUT_FRAMES)) u_miss (
    .clk(clk), .reset(reset), .clr(miss_clr), .inc(miss_inc),
    .count(miss_cnt), .at_max(miss_at_max)
  );

  // Next-state logic.  The case statement only decides whether a new
  // candidate starts or a commit happens; those two actions are applied
  // afterwards so every path that reaches them behaves identically.
  always_comb begin
    state_n        = state;
    shown_n        = shown;
    cand_n         = cand;
    label_change_n = 1'b0;
    conf_clr       = 1'b0;
    conf_inc       = 1'b0;
    hold_clr       = 1'b0;
    hold_inc       = 1'b0;
    miss_clr       = 1'b0;
    miss_inc       = 1'b0;
    do_commit      = 1'b0;
    do_start       = 1'b0;
    commit_shape   = cand;

    if (clear) begin
      state_n        = ST_IDLE;
      shown_n        = SH_NONE;
      cand_n         = SH_NONE;
      conf_clr       = 1'b1;
      hold_clr       = 1'b1;
      miss_clr       = 1'b1;
      label_change_n = (shown != SH_NONE);
    end else if (frame_done) begin
      case (state)
        ST_IDLE: begin
          if (cls != SH_NONE) do_start = 1'b1;
        end
        ST_CONFIRM: begin
          if (cls == cand) begin
            if (conf_done) do_commit = 1'b1;
            else conf_inc = 1'b1;
          end else if (cls != SH_NONE) begin
            do_start = 1'b1;
          end else if (shown != SH_NONE) begin
            state_n  = ST_SHOW;
            miss_inc = 1'b1;
          end else begin
            state_n  = ST_IDLE;
            cand_n   = SH_NONE;
            conf_clr = 1'b1;
          end
        end
        ST_SHOW: begin
          hold_inc = 1'b1;
          if (cls == shown) begin
            miss_clr = 1'b1;
          end else if (cls == SH_NONE) begin
            if (hold_expired && miss_timeout) begin
              state_n        = ST_IDLE;
              shown_n        = SH_NONE;
              cand_n         = SH_NONE;
              label_change_n = 1'b1;
              conf_clr       = 1'b1;
              hold_clr       = 1'b1;
              hold_inc       = 1'b0;
              miss_clr       = 1'b1;
            end else begin
              miss_inc = 1'b1;
            end
          end else if (hold_expired) begin
            do_start = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          shown_n = SH_NONE;
          cand_n  = SH_NONE;
        end
      endcase

      // A single-frame confirm window means a new shape commits immediately.
      if (do_start) begin
        if (CONFIRM_FRAMES == 1) begin
          do_commit    = 1'b1;
          commit_shape = cls;
        end else begin
          state_n  = ST_CONFIRM;
          cand_n   = cls;
          conf_clr = 1'b1;
          conf_inc = 1'b1;
        end
      end

      if (do_commit) begin
        state_n        = ST_SHOW;
        shown_n        = commit_shape;
        cand_n         = commit_shape;
        conf_clr       = 1'b1;
        conf_inc       = 1'b0;
        hold_clr       = 1'b1;
        hold_inc       = 1'b0;
        miss_clr       = 1'b1;
        miss_inc       = 1'b0;
        label_change_n = (commit_shape != shown);
      end
    end
  end

  // The display outputs are flops decoded from the next label, so they are
  // glitch-free and can never show two shapes at once, even out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      shown        <= SH_NONE;
      cand         <= SH_NONE;
      circle       <= 1'b0;
      square       <= 1'b0;
      triangle     <= 1'b0;
      label_change <= 1'b0;
    end else begin
      state        <= state_n;
      shown        <= shown_n;
      cand         <= cand_n;
      circle       <= (shown_n == SH_CIRCLE);
      square       <= (shown_n == SH_SQUARE);
      triangle     <= (shown_n == SH_TRIANGLE);
      label_change <= label_change_n;
    end
  end

endmodule

// File: tb/tb_shape_display_ctrl.sv
// Self-checking bench for shape_display_ctrl with CONFIRM=3, HOLD=4, TIMEOUT=2.
// Each table entry is one driven cycle followed by one quiet cycle; expected
// outputs are queued when a cycle is driven and compared after the edge.
module tb_shape_display_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic frame_done, det_circle, det_square, det_triangle, clear;
  logic circle, square, triangle, label_change;

  int total = 0;
  int bad   = 0;
  int step  = 0;

  typedef struct {
    logic       fd, c, s, t, clr;
    logic [2:0] leds;
    logic       lc;
  } vec_t;

  typedef struct {
    logic [2:0] leds;
    logic       lc;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  shape_display_ctrl #(
    .CONFIRM_FRAMES(3),
    .HOLD_FRAMES(4),
    .TIMEOUT_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_done(frame_done),
    .det_circle(det_circle),
    .det_square(det_square),
    .det_triangle(det_triangle),
    .clear(clear),
    .circle(circle),
    .square(square),
    .triangle(triangle),
    .label_change(label_change)
  );

  function automatic vec_t v(input logic fd, input logic c, input logic s, input logic t,
                             input logic clr, input logic [2:0] leds, input logic lc);
    vec_t r;
    r.fd = fd; r.c = c; r.s = s; r.t = t; r.clr = clr; r.leds = leds; r.lc = lc;
    return r;
  endfunction

  task automatic compareNow(input string name, input logic [2:0] want_leds, input logic want_lc);
    total++;
    if ({circle, square, triangle} !== want_leds) begin
      bad++;
      $display("[TB] FAIL %s leds got=%b want=%b", name, {circle, square, triangle}, want_leds);
    end
    total++;
    if (label_change !== want_lc) begin
      bad++;
      $display("[TB] FAIL %s label_change got=%b want=%b", name, label_change, want_lc);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard empty got=none want=entry");
    end else begin
      e = sb_q.pop_front();
      compareNow($sformatf("step%0d", e.tag), e.leds, e.lc);
    end
  endtask

  // Drives one cycle of the given inputs, then one quiet cycle; each cycle's
  // expectation is queued before its clock edge and checked just after it.
  task automatic applyStimulus(input vec_t x);
    exp_t e;
    @(negedge clk);
    frame_done = x.fd; det_circle = x.c; det_square = x.s; det_triangle = x.t; clear = x.clr;
    e.leds = x.leds; e.lc = x.lc; e.tag = step;
    sb_q.push_back(e);
    @(posedge clk);
    #1 checkOutput();
    @(negedge clk);
    frame_done = 1'b0; det_circle = 1'b0; det_square = 1'b0; det_triangle = 1'b0; clear = 1'b0;
    e.lc = 1'b0; e.tag = step + 1000;
    sb_q.push_back(e);
    @(posedge clk);
    #1 checkOutput();
    step++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // 1: idle frames stay blank
    for (int i = 0; i < 5; i++) vecs.push_back(v(1, 0, 0, 0, 0, 3'b000, 0));
    // 2: circle confirm, then held
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b100, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3'b000, 1));
    // 3: square, triangle ignored during hold, then triangle takes over
    vecs.push_back(v(1, 0, 1, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 0, 1, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 0, 1, 0, 0, 3'b010, 1));
    vecs.push_back(v(1, 0, 0, 1, 0, 3'b010, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 3'b010, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 3'b010, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 3'b010, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 3'b010, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 3'b010, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 3'b001, 1));
    vecs.push_back(v(1, 0, 0, 1, 0, 3'b001, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3'b000, 1));
    // 4: timeout after hold, single miss during hold keeps label
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b100, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(v(1, 1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 3'b100, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 3'b000, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b100, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 3'b100, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3'b000, 1));
    // 5: priority encode, det_* ignored without frame_done
    vecs.push_back(v(1, 1, 1, 1, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 1, 1, 0, 3'b000, 0));
    vecs.push_back(v(1, 1, 1, 1, 0, 3'b100, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 3'b100, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 3'b100, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 3'b000, 1));
    vecs.push_back(v(1, 0, 1, 1, 0, 3'b000, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 3'b000, 0));
    vecs.push_back(v(1, 0, 1, 1, 0, 3'b010, 1));
    // 6: clear beats a simultaneous frame; clear while blank gives no pulse
    vecs.push_back(v(1, 0, 1, 0, 1, 3'b000, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 3'b000, 0));
    vecs.push_back(v(1, 0, 1, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 0, 1, 0, 0, 3'b000, 0));
    vecs.push_back(v(1, 0, 1, 0, 0, 3'b010, 1));

    reset = 1'b1;
    frame_done = 1'b0; det_circle = 1'b0; det_square = 1'b0; det_triangle = 1'b0; clear = 1'b0;
    #3 compareNow("reset_state", 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released, running %0d table vectors", vecs.size());

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Async reset while a new candidate is being confirmed over a shown square.
    for (int i = 0; i < 4; i++) applyStimulus(v(1, 0, 1, 0, 0, 3'b010, 0));
    applyStimulus(v(1, 0, 0, 1, 0, 3'b010, 0));
    @(negedge clk);
    frame_done = 1'b1; det_triangle = 1'b1;
    #2 reset = 1'b1;
    #1 compareNow("async_reset_now", 3'b000, 1'b0);
    @(posedge clk);
    #1 compareNow("async_reset_held", 3'b000, 1'b0);
    @(negedge clk);
    frame_done = 1'b0; det_triangle = 1'b0;
    reset = 1'b0;
    // Confirm count must restart from zero after reset.
    applyStimulus(v(1, 0, 0, 1, 0, 3'b000, 0));
    applyStimulus(v(1, 0, 0, 1, 0, 3'b000, 0));
    applyStimulus(v(1, 0, 0, 1, 0, 3'b001, 1));

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
